// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - buffered TX/RX byte bridge between the CPU register file and uart_lite
// TX FIFO drained by a three-state handshake FSM; RX FIFO with first-word-fall-through head.
module uart_fifo_bridge #(
   parameter int TX_DEPTH  = 16,
   parameter int RX_DEPTH  = 16,
   parameter int DATA_BITS = 8,
   localparam int TXLW = $clog2(TX_DEPTH + 1),
   localparam int RXLW = $clog2(RX_DEPTH + 1),
   localparam int TPW  = $clog2(TX_DEPTH),
   localparam int RPW  = $clog2(RX_DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_wr_en,
   input  logic [DATA_BITS-1:0] tx_wr_data,
   output logic                 tx_full,
   output logic                 tx_empty,
   output logic [TXLW-1:0]      tx_level,
   output logic                 tx_overflow,
   input  logic                 rx_rd_en,
   output logic [DATA_BITS-1:0] rx_rd_data,
   output logic                 rx_empty,
   output logic [RXLW-1:0]      rx_level,
   output logic                 rx_overflow,
   input  logic                 ovf_clr,
   input  logic                 uart_tx_rdy,
   output logic                 uart_tx_vld,
   output logic [DATA_BITS-1:0] uart_tx_data,
   input  logic                 uart_rx_valid,
   input  logic [DATA_BITS-1:0] uart_rx_data
);

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_RDY} state_t;

   state_t               state, state_nxt;
   logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
   logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
   logic [TPW-1:0]       tx_wp, tx_rp;
   logic [RPW-1:0]       rx_wp, rx_rp;
   logic                 tx_push, tx_pop, rx_push, rx_pop, rx_full;

   assign tx_full    = (tx_level == TXLW'(TX_DEPTH));
   assign tx_empty   = (tx_level == '0);
   assign rx_full    = (rx_level == RXLW'(RX_DEPTH));
   assign rx_empty   = (rx_level == '0);
   assign tx_push    = tx_wr_en && (!tx_full || tx_pop);
   assign rx_pop     = rx_rd_en && !rx_empty;
   assign rx_push    = uart_rx_valid && (!rx_full || rx_pop);
   assign rx_rd_data = rx_empty ? '0 : rx_mem[rx_rp];

   // A strobe is only ever issued leaving IDLE, so a stale tx_rdy cannot cause a resend.
   always_comb begin
      state_nxt = state;
      tx_pop    = 1'b0;
      case (state)
         IDLE: begin
            if (!tx_empty && uart_tx_rdy) begin
               tx_pop    = 1'b1;
               state_nxt = WAIT_BUSY;
            end
         end
         WAIT_BUSY: if (!uart_tx_rdy) state_nxt = WAIT_RDY;
         WAIT_RDY:  if (uart_tx_rdy)  state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= tx_wr_data;
      if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         uart_tx_vld  <= 1'b0;
         uart_tx_data <= '0;
         tx_wp        <= '0;
         tx_rp        <= '0;
         tx_level     <= '0;
         tx_overflow  <= 1'b0;
      end else begin
         state       <= state_nxt;
         uart_tx_vld <= tx_pop;
         if (tx_pop)  uart_tx_data <= tx_mem[tx_rp];
         if (tx_push) tx_wp <= tx_wp + TPW'(1);
         if (tx_pop)  tx_rp <= tx_rp + TPW'(1);
         if (tx_push && !tx_pop)      tx_level <= tx_level + TXLW'(1);
         else if (!tx_push && tx_pop) tx_level <= tx_level - TXLW'(1);
         // A fresh drop outranks a clear in the same cycle.
         if (tx_wr_en && !tx_push) tx_overflow <= 1'b1;
         else if (ovf_clr)         tx_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_wp       <= '0;
         rx_rp       <= '0;
         rx_level    <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + RPW'(1);
         if (rx_pop)  rx_rp <= rx_rp + RPW'(1);
         if (rx_push && !rx_pop)      rx_level <= rx_level + RXLW'(1);
         else if (!rx_push && rx_pop) rx_level <= rx_level - RXLW'(1);
         if (uart_rx_valid && !rx_push) rx_overflow <= 1'b1;
         else if (ovf_clr)              rx_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - directed scoreboard bench for uart_fifo_bridge
// A uart_lite model holds tx_rdy low for 10 cycles after each strobe.
module tb_uart_fifo_bridge;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_wr_en;
   logic [7:0] tx_wr_data;
   logic       tx_full, tx_empty, tx_overflow;
   logic [4:0] tx_level;
   logic       rx_rd_en;
   logic [7:0] rx_rd_data;
   logic       rx_empty, rx_overflow;
   logic [4:0] rx_level;
   logic       ovf_clr;
   logic       uart_tx_rdy = 1'b0;
   logic       uart_tx_vld;
   logic [7:0] uart_tx_data;
   logic       uart_rx_valid;
   logic [7:0] uart_rx_data;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         strobe_cnt = 0;
   int         busy_cnt   = 0;
   bit         hold_rdy_low = 1'b0;
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   logic [31:0] exp_rx;

   uart_fifo_bridge dut (
      .clk(clk), .reset(reset),
      .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
      .tx_full(tx_full), .tx_empty(tx_empty), .tx_level(tx_level), .tx_overflow(tx_overflow),
      .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
      .rx_overflow(rx_overflow), .ovf_clr(ovf_clr),
      .uart_tx_rdy(uart_tx_rdy), .uart_tx_vld(uart_tx_vld), .uart_tx_data(uart_tx_data),
      .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // uart_lite model and TX scoreboard consumer
   always @(negedge clk) begin
      logic [31:0] exp_b;
      if (reset) begin
         busy_cnt    = 0;
         uart_tx_rdy = 1'b0;
      end else begin
         if (uart_tx_vld) begin
            chk("tx_no_double_send", 32'(busy_cnt == 0), 32'd1);
            exp_b = (txq.size() > 0) ? {24'h0, txq.pop_front()} : 32'h100;
            chk("tx_strobe_data", {24'h0, uart_tx_data}, exp_b);
            strobe_cnt++;
            busy_cnt = 10;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end
         uart_tx_rdy = (busy_cnt == 0) && !hold_rdy_low;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_strobes(input int target, input int budget);
      int i = 0;
      while (strobe_cnt < target && i < budget) begin
         @(posedge clk);
         i++;
      end
      #1;
      chk("tx_strobe_count", strobe_cnt, target);
   endtask

   task automatic settle_tx();
      for (int i = 0; i < 50 && (busy_cnt != 0 || !uart_tx_rdy); i++) @(posedge clk);
      tick();
      tick();
   endtask

   task automatic rx_read_check();
      exp_rx = (rxq.size() > 0) ? {24'h0, rxq.pop_front()} : 32'h100;
      chk("rx_rd_data", {24'h0, rx_rd_data}, exp_rx);
      rx_rd_en = 1'b1;
      tick();
      rx_rd_en = 1'b0;
   endtask

   initial begin
      int base;
      reset = 1'b1;
      tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0; ovf_clr = 1'b0;
      uart_rx_valid = 1'b0; uart_rx_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_tx_level", tx_level, 0);
      chk("rst_rx_level", rx_level, 0);
      chk("rst_tx_empty", tx_empty, 1);
      chk("rst_rx_empty", rx_empty, 1);
      chk("rst_tx_full", tx_full, 0);
      chk("rst_tx_overflow", tx_overflow, 0);
      chk("rst_rx_overflow", rx_overflow, 0);
      chk("rst_uart_tx_vld", uart_tx_vld, 0);
      chk("rst_uart_tx_data", uart_tx_data, 0);
      chk("rst_rx_rd_data", rx_rd_data, 0);

      // TX ordering and latency
      tick();
      tx_wr_en = 1'b1; tx_wr_data = 8'h41; txq.push_back(8'h41);
      tick();
      chk("tx_lat_empty_low", tx_empty, 0);
      chk("tx_lat_vld_not_yet", uart_tx_vld, 0);
      chk("tx_lat_level", tx_level, 1);
      tx_wr_data = 8'h42; txq.push_back(8'h42);
      tick();
      chk("tx_lat_vld", uart_tx_vld, 1);
      chk("tx_lat_data", uart_tx_data, 8'h41);
      chk("tx_pushpop_level", tx_level, 1);
      tx_wr_data = 8'h43; txq.push_back(8'h43);
      tick();
      tx_wr_en = 1'b0;
      wait_strobes(3, 200);
      settle_tx();
      chk("tx_order_empty", tx_empty, 1);
      chk("tx_order_strobes", strobe_cnt, 3);
      chk("tx_order_held_data", uart_tx_data, 8'h43);
      chk("tx_order_queue_drained", txq.size(), 0);

      // TX overflow with uart busy
      hold_rdy_low = 1'b1;
      tick();
      tick();
      for (int i = 0; i <= 16; i++) begin
         tx_wr_en = 1'b1; tx_wr_data = 8'(i);
         if (i < 16) txq.push_back(8'(i));
         tick();
      end
      tx_wr_en = 1'b0;
      chk("tx_ovf_full", tx_full, 1);
      chk("tx_ovf_level", tx_level, 16);
      chk("tx_ovf_flag", tx_overflow, 1);
      tx_wr_en = 1'b1; tx_wr_data = 8'h77; ovf_clr = 1'b1;
      tick();
      tx_wr_en = 1'b0; ovf_clr = 1'b0;
      chk("tx_ovf_clr_race", tx_overflow, 1);
      chk("tx_ovf_race_level", tx_level, 16);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("tx_ovf_cleared", tx_overflow, 0);
      base = strobe_cnt;
      hold_rdy_low = 1'b0;
      wait_strobes(base + 16, 16 * 14 + 40);
      settle_tx();
      chk("tx_ovf_drained_empty", tx_empty, 1);
      chk("tx_ovf_queue_drained", txq.size(), 0);

      // RX burst and overflow
      for (int i = 0; i <= 16; i++) begin
         uart_rx_valid = 1'b1; uart_rx_data = 8'hA0 + 8'(i);
         if (i < 16) rxq.push_back(8'hA0 + 8'(i));
         tick();
         if (i == 0) begin
            chk("rx_lat_level", rx_level, 1);
            chk("rx_lat_empty", rx_empty, 0);
            chk("rx_lat_data", rx_rd_data, 8'hA0);
         end
      end
      uart_rx_valid = 1'b0;
      chk("rx_burst_level", rx_level, 16);
      chk("rx_burst_overflow", rx_overflow, 1);
      for (int i = 0; i < 16; i++) rx_read_check();
      chk("rx_burst_empty", rx_empty, 1);
      chk("rx_burst_data_zero", rx_rd_data, 0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("rx_ovf_cleared", rx_overflow, 0);

      // RX simultaneous push and pop at full
      for (int i = 0; i < 16; i++) begin
         uart_rx_valid = 1'b1; uart_rx_data = 8'hC0 + 8'(i);
         rxq.push_back(8'hC0 + 8'(i));
         tick();
      end
      uart_rx_valid = 1'b0;
      chk("rx_full_level", rx_level, 16);
      exp_rx = {24'h0, rxq.pop_front()};
      chk("rx_full_head", {24'h0, rx_rd_data}, exp_rx);
      uart_rx_valid = 1'b1; uart_rx_data = 8'h55; rx_rd_en = 1'b1;
      rxq.push_back(8'h55);
      tick();
      uart_rx_valid = 1'b0; rx_rd_en = 1'b0;
      chk("rx_pushpop_level", rx_level, 16);
      chk("rx_pushpop_no_ovf", rx_overflow, 0);
      for (int i = 0; i < 16; i++) rx_read_check();
      chk("rx_pushpop_empty", rx_empty, 1);

      // Empty read has no side effect
      rx_rd_en = 1'b1;
      tick();
      rx_rd_en = 1'b0;
      chk("rx_empty_rd_level", rx_level, 0);
      chk("rx_empty_rd_data", rx_rd_data, 0);
      chk("rx_empty_rd_flag", rx_empty, 1);
      chk("rx_empty_rd_no_ovf", rx_overflow, 0);

      // Reset mid-stream while a strobe is in flight
      hold_rdy_low = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         tx_wr_en = 1'b1; tx_wr_data = 8'h31 + 8'(i); txq.push_back(8'h31 + 8'(i));
         uart_rx_valid = 1'b1; uart_rx_data = 8'h91 + 8'(i);
         tick();
      end
      tx_wr_en = 1'b0; uart_rx_valid = 1'b0;
      chk("mid_tx_level", tx_level, 3);
      chk("mid_rx_level", rx_level, 3);
      chk("mid_rx_head", rx_rd_data, 8'h91);
      hold_rdy_low = 1'b0;
      for (int i = 0; i < 20 && !uart_tx_vld; i++) tick();
      chk("mid_vld_before_reset", uart_tx_vld, 1);
      reset = 1'b1;
      #1;
      chk("async_rst_vld", uart_tx_vld, 0);
      chk("async_rst_tx_data", uart_tx_data, 0);
      chk("async_rst_tx_level", tx_level, 0);
      chk("async_rst_rx_level", rx_level, 0);
      chk("async_rst_tx_empty", tx_empty, 1);
      chk("async_rst_rx_empty", rx_empty, 1);
      chk("async_rst_rx_data", rx_rd_data, 0);
      chk("async_rst_tx_full", tx_full, 0);
      txq.delete();
      rxq.delete();
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_tx_level", tx_level, 0);
      chk("post_rst_rx_level", rx_level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
